multiport_regfile: RTL and testbench
====================================

// Module: multiport_regfile
// PURPOSE
//  Parametrised architectural register file for the ARM core.
//  - NUM_RD combinational read ports.
//  - Two write ports: port 3 (result/load) and port 1 (base writeback / long-mul hi).
//  - R15 reads are served from an external pc_plus8 value.
//  - Optional same-cycle write-through bypass.
//  - Per-register pending scoreboard for multi-cycle producers (multiplier, loads).
//  Replaces the fixed 3-read/1-write file inside the datapath.
// PARAMETERS
//  DATA_W     32  register width in bits
//  NUM_REGS   16  number of architectural registers (power of 2)
//  NUM_RD     3   number of read ports (1..4)
//  PC_IDX     15  index whose reads return pc_plus8 and whose writes are dropped
//  BYPASS     0   1: a read of an address written this cycle returns the write data
//  ADDR_W     $clog2(NUM_REGS)  derived; not overridden
// PORTS
//  clk        in   1              rising-edge clock
//  reset      in   1              asynchronous, active-high reset
//  ra         in   NUM_RD*ADDR_W  read addresses; port i = ra[i*ADDR_W +: ADDR_W]
//  rd         out  NUM_RD*DATA_W  read data, combinational
//  rd_busy    out  NUM_RD         1 = register at ra[i] is pending
//  pc_plus8   in   DATA_W         value returned for reads of PC_IDX
//  we3        in   1              write enable, port 3
//  wa3        in   ADDR_W         write address, port 3
//  wd3        in   DATA_W         write data, port 3
//  we1        in   1              write enable, port 1
//  wa1        in   ADDR_W         write address, port 1
//  wd1        in   DATA_W         write data, port 1
//  pend_set   in   1              mark pend_addr pending (multi-cycle op issued)
//  pend_addr  in   ADDR_W         register being reserved
//  any_busy   out  1              OR of all pending bits
// BEHAVIOUR
//  Reset
//   - Asynchronous, active-high; clears all registers and all pending bits to 0.
//   - Outputs during reset: rd = 0 for non-PC addresses, rd_busy = 0, any_busy = 0.
//   - Reset asserted mid-operation discards any write due on that edge.
//  Writes
//   - Latency 1: on the rising clk edge a port with we=1 updates reg[wa] <= wd.
//   - wa3 == wa1 with both enabled: port 3 wins; port 1's data is discarded.
//   - Writes to PC_IDX are ignored; PC is owned by the fetch unit.
//  Reads
//   - Combinational: rd[i] = reg[ra[i]].
//   - ra[i] == PC_IDX: rd[i] = pc_plus8 always; bypass does not apply.
//   - BYPASS=1: if ra[i] matches an enabled write address (port 3 first, then port 1),
//     rd[i] = that write's data in the same cycle.
//   - BYPASS=0: the old value is returned until after the edge.
//  Scoreboard
//   - Any write (we3 or we1) to register r clears pend[r] on that edge.
//   - pend_set sets pend[pend_addr] on the edge.
//   - Set and clear of the same register on one edge: set wins (back-to-back producer).
//   - pend_set with pend_addr == PC_IDX is ignored.
//   - rd_busy[i] = pend[ra[i]]; it is 0 for PC_IDX.
//   - BYPASS=1 and a same-cycle write to ra[i]: rd_busy[i] = 0.
//   - any_busy is registered-state only; no combinational path from inputs.
//  Width rules
//   - All data is DATA_W bits; no sign extension or truncation inside the block.
// STRUCTURE
//  - regfile_pkg: ADDR_W function, reg_addr_t / reg_data_t typedefs, PC_IDX default.
//  - Sub-module reg_scoreboard: NUM_REGS pending bits, set/clear priority, any_busy.
//  - Storage array, write-priority logic and the read-mux generate loop stay in the top.
// TESTING
//  1. Reset mid-run after writing r1=15 -> reg[1]=0, any_busy=0, while reset is still high.
//  2. we3: r1<=15; we1: r11<=32 on the same edge -> next cycle ra0=1 gives 15, ra1=11 gives 32.
//  3. we3 and we1 both to r4 (wd3=0xAAAA_0000, wd1=0x5555) -> r4 = 0xAAAA_0000.
//  4. pc_plus8=136, ra0=15; then we3 to r15 with 0xDEAD -> rd0 stays 136, storage unchanged.
//  5. BYPASS=1: we3 r2<=7 with ra0=2 -> rd0=7 in the same cycle; BYPASS=0 -> old value, 7 next cycle.
//  6. pend_set r5 -> rd_busy=1, any_busy=1; next edge we3 r5 with pend_set r5 -> still busy;
//     following edge we3 r5 alone -> rd_busy=0.

Source files
------------

// File: rtl/multiport_regfile_pkg.sv
// Shared parameters, address-width helper and register typedefs for the register file.
package multiport_regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 16;
    localparam int NUM_RD_DEF   = 3;
    localparam int PC_IDX_DEF   = 15;

    // Address width for a file of n registers; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [$clog2(NUM_REGS_DEF)-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0]           reg_data_t;

endpackage

// File: rtl/multiport_regfile_if.sv
// Datapath-side bus of the register file: read ports, two write ports, scoreboard reservation.
interface multiport_regfile_if
    import multiport_regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = NUM_RD_DEF
);
    localparam int ADDR_W = addr_w(NUM_REGS);

    logic [NUM_RD*ADDR_W-1:0] ra;
    logic [NUM_RD*DATA_W-1:0] rd;
    logic [NUM_RD-1:0]        rd_busy;
    logic [DATA_W-1:0]        pc_plus8;
    logic                     we3;
    logic [ADDR_W-1:0]        wa3;
    logic [DATA_W-1:0]        wd3;
    logic                     we1;
    logic [ADDR_W-1:0]        wa1;
    logic [DATA_W-1:0]        wd1;
    logic                     pend_set;
    logic [ADDR_W-1:0]        pend_addr;
    logic                     any_busy;

    modport master (
        output ra, pc_plus8, we3, wa3, wd3, we1, wa1, wd1, pend_set, pend_addr,
        input  rd, rd_busy, any_busy
    );

    modport slave (
        input  ra, pc_plus8, we3, wa3, wd3, we1, wa1, wd1, pend_set, pend_addr,
        output rd, rd_busy, any_busy
    );

endinterface

// File: rtl/multiport_regfile_reg_scoreboard.sv
// Pending-bit scoreboard: one bit per register, reserved by multi-cycle producers,
// released by the write that delivers the result.
module reg_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int PC_IDX   = 15,
    parameter int ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we3_i,
    input  logic [ADDR_W-1:0]   wa3_i,
    input  logic                we1_i,
    input  logic [ADDR_W-1:0]   wa1_i,
    input  logic                pend_set_i,
    input  logic [ADDR_W-1:0]   pend_addr_i,
    output logic [NUM_REGS-1:0] pend_o,
    output logic                any_busy_o
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    // Next pending state: writes clear, a reservation on the same edge overrides the clear.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        pend_d = pend_q;
        if (we3_i) pend_d[wa3_i] = 1'b0;
        if (we1_i) pend_d[wa1_i] = 1'b0;
        if (pend_set_i && (pend_addr_i != ADDR_W'(PC_IDX))) pend_d[pend_addr_i] = 1'b1;
    end

    // Pending-bit register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    assign pend_o     = pend_q;
    // Driven from state only, so a same-cycle reservation never shows combinationally.
    assign any_busy_o = |pend_q;

endmodule

// File: rtl/multiport_regfile.sv
// Architectural register file: NUM_RD combinational read ports, two write ports
// (port 3 has priority), PC reads served from pc_plus8, optional write-through bypass.
module multiport_regfile
    import multiport_regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int PC_IDX   = PC_IDX_DEF,
    parameter int BYPASS   = 0
) (
    input  logic               clk,
    input  logic               reset,
    multiport_regfile_if.slave rf
);

    localparam int ADDR_W = addr_w(NUM_REGS);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] pend;

    // Next storage contents: port 3 wins over port 1; the PC slot is owned by fetch.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_d[r] = regs_q[r];
            if (r != PC_IDX) begin
                if (rf.we3 && (rf.wa3 == ADDR_W'(r)))      regs_d[r] = rf.wd3;
                else if (rf.we1 && (rf.wa1 == ADDR_W'(r))) regs_d[r] = rf.wd1;
            end
        end
    end

    // Storage array with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: this array is reset on purpose: software may read any register before writing it.
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .PC_IDX   (PC_IDX),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .we3_i       (rf.we3),
        .wa3_i       (rf.wa3),
        .we1_i       (rf.we1),
        .wa1_i       (rf.wa1),
        .pend_set_i  (rf.pend_set),
        .pend_addr_i (rf.pend_addr),
        .pend_o      (pend),
        .any_busy_o  (rf.any_busy)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hit3;
        logic              hit1;
        logic [DATA_W-1:0] data;
        logic              busy;

        assign addr = rf.ra[i*ADDR_W +: ADDR_W];
        // Bypass is suppressed during reset so reads show the cleared state.
        assign hit3 = (BYPASS != 0) && !reset && rf.we3 && (rf.wa3 == addr);
        assign hit1 = (BYPASS != 0) && !reset && rf.we1 && (rf.wa1 == addr);

        // Read mux: PC first, then same-cycle write data, else stored value and pending bit.
        always_comb begin
            data = regs_q[addr];
            busy = pend[addr];
            if (addr == ADDR_W'(PC_IDX)) begin
                data = rf.pc_plus8;
                busy = 1'b0;
            end else if (hit3) begin
                data = rf.wd3;
                busy = 1'b0;
            end else if (hit1) begin
                data = rf.wd1;
                busy = 1'b0;
            end
        end

        assign rf.rd[i*DATA_W +: DATA_W] = data;
        assign rf.rd_busy[i]             = busy;
    end

endmodule

// File: tb/tb_multiport_regfile.sv
// Self-checking bench: two register files (BYPASS=0 and BYPASS=1) driven by identical
// stimulus and compared against an array-based model of the architectural state.
module tb_multiport_regfile;
    import multiport_regfile_pkg::*;

    localparam int DW  = 32;
    localparam int NR  = 16;
    localparam int NRD = 3;
    localparam int AW  = 4;
    localparam int PC  = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multiport_regfile_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) if0 ();
    multiport_regfile_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) if1 ();

    assign if1.ra        = if0.ra;
    assign if1.pc_plus8  = if0.pc_plus8;
    assign if1.we3       = if0.we3;
    assign if1.wa3       = if0.wa3;
    assign if1.wd3       = if0.wd3;
    assign if1.we1       = if0.we1;
    assign if1.wa1       = if0.wa1;
    assign if1.wd1       = if0.wd1;
    assign if1.pend_set  = if0.pend_set;
    assign if1.pend_addr = if0.pend_addr;

    multiport_regfile #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .PC_IDX(PC), .BYPASS(0))
        dut0 (.clk(clk), .reset(reset), .rf(if0.slave));
    multiport_regfile #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .PC_IDX(PC), .BYPASS(1))
        dut1 (.clk(clk), .reset(reset), .rf(if1.slave));

    // Architectural model
    reg_data_t mreg  [NR];
    bit        mpend [NR];
    int        n_cmp = 0;
    int        n_err = 0;

    function automatic void model_clear();
        for (int r = 0; r < NR; r++) begin
            mreg[r]  = '0;
            mpend[r] = 1'b0;
        end
    endfunction

    function automatic reg_addr_t ra_of(input int p);
        return if0.ra[p*AW +: AW];
    endfunction

    function automatic reg_data_t exp_rd(input bit byp, input int p);
        reg_addr_t a = ra_of(p);
        if (a == PC) return if0.pc_plus8;
        if (byp && !reset) begin
            if (if0.we3 && if0.wa3 == a) return if0.wd3;
            if (if0.we1 && if0.wa1 == a) return if0.wd1;
        end
        return mreg[a];
    endfunction

    function automatic bit exp_busy(input bit byp, input int p);
        reg_addr_t a = ra_of(p);
        if (a == PC) return 1'b0;
        if (byp && !reset && ((if0.we3 && if0.wa3 == a) || (if0.we1 && if0.wa1 == a))) return 1'b0;
        return mpend[a];
    endfunction

    function automatic bit exp_any();
        bit b = 1'b0;
        for (int r = 0; r < NR; r++) b |= mpend[r];
        return b;
    endfunction

    // Architectural effect of one clock edge.
    function automatic void model_edge();
        if (reset) begin
            model_clear();
            return;
        end
        if (if0.we1 && if0.wa1 != PC) mreg[if0.wa1] = if0.wd1;
        if (if0.we3 && if0.wa3 != PC) mreg[if0.wa3] = if0.wd3;
        if (if0.we1) mpend[if0.wa1] = 1'b0;
        if (if0.we3) mpend[if0.wa3] = 1'b0;
        if (if0.pend_set && if0.pend_addr != PC) mpend[if0.pend_addr] = 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        if0.we3 = 1'b0; if0.wa3 = '0; if0.wd3 = '0;
        if0.we1 = 1'b0; if0.wa1 = '0; if0.wd1 = '0;
        if0.pend_set = 1'b0; if0.pend_addr = '0;
    endtask

    task automatic set_ra(input reg_addr_t a0, input reg_addr_t a1, input reg_addr_t a2);
        if0.ra = {a2, a1, a0};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_clear();
        idle();
        if0.pc_plus8 = 32'd0;
        set_ra(4'd1, 4'd2, 4'd3);
        #3;
        n_cmp++; if (if0.rd !== '0) begin n_err++; $display("FAIL reset_rd_byp0 got=%h exp=0", if0.rd); end
        n_cmp++; if (if1.rd !== '0) begin n_err++; $display("FAIL reset_rd_byp1 got=%h exp=0", if1.rd); end
        n_cmp++; if (if0.rd_busy !== '0 || if0.any_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b/%b exp=0/0", if0.rd_busy, if0.any_busy); end
        @(negedge clk);
        reset = 1'b0;
        // r1 <= 15 and reserve r3
        if0.we3 = 1'b1; if0.wa3 = 4'd1; if0.wd3 = 32'd15;
        if0.pend_set = 1'b1; if0.pend_addr = 4'd3;
        step();
        idle();
        #1;
        n_cmp++; if (if0.rd[0 +: DW] !== 32'd15) begin n_err++; $display("FAIL pre_reset_r1 got=%0d exp=15", if0.rd[0 +: DW]); end
        n_cmp++; if (if0.any_busy !== 1'b1) begin n_err++; $display("FAIL pre_reset_any got=%b exp=1", if0.any_busy); end
        // reset mid-run with a write pending on the next edge
        if0.we3 = 1'b1; if0.wa3 = 4'd2; if0.wd3 = 32'd99;
        reset = 1'b1;
        model_clear();
        #1;
        n_cmp++; if (if0.rd[0 +: DW] !== 32'd0) begin n_err++; $display("FAIL midreset_r1 got=%0d exp=0", if0.rd[0 +: DW]); end
        n_cmp++; if (if1.any_busy !== 1'b0 || if0.any_busy !== 1'b0) begin n_err++; $display("FAIL midreset_any got=%b%b exp=00", if0.any_busy, if1.any_busy); end
        n_cmp++; if (if1.rd[DW +: DW] !== 32'd0) begin n_err++; $display("FAIL midreset_bypass got=%0d exp=0", if1.rd[DW +: DW]); end
        step();
        reset = 1'b0;
        idle();
        #1;
        n_cmp++; if (if0.rd[DW +: DW] !== 32'd0) begin n_err++; $display("FAIL reset_discards_write got=%0d exp=0", if0.rd[DW +: DW]); end
    endtask

    task automatic test_dual_write();
        if0.we3 = 1'b1; if0.wa3 = 4'd1;  if0.wd3 = 32'd15;
        if0.we1 = 1'b1; if0.wa1 = 4'd11; if0.wd1 = 32'd32;
        step();
        idle();
        set_ra(4'd1, 4'd11, 4'd0);
        #1;
        n_cmp++; if (if0.rd[0 +: DW] !== 32'd15) begin n_err++; $display("FAIL dual_r1 got=%0d exp=15", if0.rd[0 +: DW]); end
        n_cmp++; if (if0.rd[DW +: DW] !== 32'd32) begin n_err++; $display("FAIL dual_r11 got=%0d exp=32", if0.rd[DW +: DW]); end
        if0.we3 = 1'b1; if0.wa3 = 4'd4; if0.wd3 = 32'hAAAA_0000;
        if0.we1 = 1'b1; if0.wa1 = 4'd4; if0.wd1 = 32'h0000_5555;
        step();
        idle();
        set_ra(4'd4, 4'd4, 4'd4);
        #1;
        n_cmp++; if (if0.rd[0 +: DW] !== 32'hAAAA_0000) begin n_err++; $display("FAIL collide_byp0 got=%h exp=aaaa0000", if0.rd[0 +: DW]); end
        n_cmp++; if (if1.rd[2*DW +: DW] !== 32'hAAAA_0000) begin n_err++; $display("FAIL collide_byp1 got=%h exp=aaaa0000", if1.rd[2*DW +: DW]); end
    endtask

    task automatic test_pc();
        if0.pc_plus8 = 32'd136;
        set_ra(4'd15, 4'd0, 4'd0);
        if0.we3 = 1'b1; if0.wa3 = 4'd15; if0.wd3 = 32'hDEAD;
        #1;
        n_cmp++; if (if1.rd[0 +: DW] !== 32'd136) begin n_err++; $display("FAIL pc_no_bypass got=%0d exp=136", if1.rd[0 +: DW]); end
        step();
        idle();
        if0.pend_set = 1'b1; if0.pend_addr = 4'd15;
        #1;
        n_cmp++; if (if0.rd[0 +: DW] !== 32'd136) begin n_err++; $display("FAIL pc_after_write got=%0d exp=136", if0.rd[0 +: DW]); end
        step();
        idle();
        if0.pc_plus8 = 32'd200;
        #1;
        n_cmp++; if (if0.rd[0 +: DW] !== 32'd200 || if1.rd[0 +: DW] !== 32'd200) begin n_err++; $display("FAIL pc_track got=%0d/%0d exp=200", if0.rd[0 +: DW], if1.rd[0 +: DW]); end
        n_cmp++; if (if0.any_busy !== 1'b0 || if0.rd_busy[0] !== 1'b0) begin n_err++; $display("FAIL pc_pend_ignored got=%b/%b exp=0/0", if0.any_busy, if0.rd_busy[0]); end
    endtask

    task automatic test_bypass();
        if0.we3 = 1'b1; if0.wa3 = 4'd2; if0.wd3 = 32'd3;
        step();
        if0.we3 = 1'b1; if0.wa3 = 4'd2; if0.wd3 = 32'd7;
        if0.we1 = 1'b1; if0.wa1 = 4'd6; if0.wd1 = 32'h66;
        set_ra(4'd2, 4'd6, 4'd0);
        #1;
        n_cmp++; if (if1.rd[0 +: DW] !== 32'd7) begin n_err++; $display("FAIL bypass3_byp1 got=%0d exp=7", if1.rd[0 +: DW]); end
        n_cmp++; if (if0.rd[0 +: DW] !== 32'd3) begin n_err++; $display("FAIL bypass3_byp0 got=%0d exp=3", if0.rd[0 +: DW]); end
        n_cmp++; if (if1.rd[DW +: DW] !== 32'h66) begin n_err++; $display("FAIL bypass1_byp1 got=%h exp=66", if1.rd[DW +: DW]); end
        n_cmp++; if (if0.rd[DW +: DW] !== 32'h0) begin n_err++; $display("FAIL bypass1_byp0 got=%h exp=0", if0.rd[DW +: DW]); end
        step();
        idle();
        #1;
        n_cmp++; if (if0.rd[0 +: DW] !== 32'd7 || if0.rd[DW +: DW] !== 32'h66) begin n_err++; $display("FAIL bypass_after got=%0d/%h exp=7/66", if0.rd[0 +: DW], if0.rd[DW +: DW]); end
        if0.we3 = 1'b1; if0.wa3 = 4'd8; if0.wd3 = 32'h83;
        if0.we1 = 1'b1; if0.wa1 = 4'd8; if0.wd1 = 32'h81;
        set_ra(4'd0, 4'd0, 4'd8);
        #1;
        n_cmp++; if (if1.rd[2*DW +: DW] !== 32'h83) begin n_err++; $display("FAIL bypass_prio got=%h exp=83", if1.rd[2*DW +: DW]); end
        step();
        idle();
    endtask

    task automatic test_scoreboard();
        set_ra(4'd5, 4'd0, 4'd0);
        if0.pend_set = 1'b1; if0.pend_addr = 4'd5;
        #1;
        n_cmp++; if (if0.any_busy !== 1'b0 || if1.any_busy !== 1'b0) begin n_err++; $display("FAIL any_busy_comb got=%b%b exp=00", if0.any_busy, if1.any_busy); end
        step();
        idle();
        #1;
        n_cmp++; if (if0.rd_busy[0] !== 1'b1 || if0.any_busy !== 1'b1) begin n_err++; $display("FAIL pend_set got=%b/%b exp=1/1", if0.rd_busy[0], if0.any_busy); end
        if0.we3 = 1'b1; if0.wa3 = 4'd5; if0.wd3 = 32'h55;
        if0.pend_set = 1'b1; if0.pend_addr = 4'd5;
        #1;
        n_cmp++; if (if1.rd_busy[0] !== 1'b0 || if0.rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL busy_bypass got=%b/%b exp=1/0", if0.rd_busy[0], if1.rd_busy[0]); end
        step();
        idle();
        #1;
        n_cmp++; if (if0.rd_busy[0] !== 1'b1 || if1.any_busy !== 1'b1) begin n_err++; $display("FAIL set_wins got=%b/%b exp=1/1", if0.rd_busy[0], if1.any_busy); end
        if0.we3 = 1'b1; if0.wa3 = 4'd5; if0.wd3 = 32'h56;
        step();
        idle();
        #1;
        n_cmp++; if (if0.rd_busy[0] !== 1'b0 || if0.any_busy !== 1'b0) begin n_err++; $display("FAIL clear got=%b/%b exp=0/0", if0.rd_busy[0], if0.any_busy); end
        n_cmp++; if (if0.rd[0 +: DW] !== 32'h56) begin n_err++; $display("FAIL clear_data got=%h exp=56", if0.rd[0 +: DW]); end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if0.ra        = 12'($urandom);
            if0.pc_plus8  = $urandom;
            if0.we3       = 1'($urandom_range(0, 1));
            if0.wa3       = 4'($urandom);
            if0.wd3       = $urandom;
            if0.we1       = 1'($urandom_range(0, 1));
            if0.wa1       = 4'($urandom);
            if0.wd1       = $urandom;
            if0.pend_set  = ($urandom_range(0, 2) == 0);
            if0.pend_addr = 4'($urandom);
            #1;
            for (int p = 0; p < NRD; p++) begin
                n_cmp++; if (if0.rd[p*DW +: DW] !== exp_rd(1'b0, p)) begin n_err++; $display("FAIL rand_rd_byp0 cyc=%0d port=%0d got=%h exp=%h", cyc, p, if0.rd[p*DW +: DW], exp_rd(1'b0, p)); end
                n_cmp++; if (if1.rd[p*DW +: DW] !== exp_rd(1'b1, p)) begin n_err++; $display("FAIL rand_rd_byp1 cyc=%0d port=%0d got=%h exp=%h", cyc, p, if1.rd[p*DW +: DW], exp_rd(1'b1, p)); end
                n_cmp++; if (if0.rd_busy[p] !== exp_busy(1'b0, p)) begin n_err++; $display("FAIL rand_busy_byp0 cyc=%0d port=%0d got=%b exp=%b", cyc, p, if0.rd_busy[p], exp_busy(1'b0, p)); end
                n_cmp++; if (if1.rd_busy[p] !== exp_busy(1'b1, p)) begin n_err++; $display("FAIL rand_busy_byp1 cyc=%0d port=%0d got=%b exp=%b", cyc, p, if1.rd_busy[p], exp_busy(1'b1, p)); end
            end
            n_cmp++; if (if0.any_busy !== exp_any() || if1.any_busy !== exp_any()) begin n_err++; $display("FAIL rand_any cyc=%0d got=%b%b exp=%b", cyc, if0.any_busy, if1.any_busy, exp_any()); end
            step();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_pc();
        test_bypass();
        test_scoreboard();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
